keccak_squeeze_unit: RTL and testbench
======================================

// Module: keccak_squeeze_unit
// PURPOSE
// - Squeeze-side output stage of the Keccak core (SHAKE-style XOF output path).
// - Requests permutations from the core and captures the RATE part of each permuted state.
// - Serialises the captured bits as OUT_WIDTH-bit words over a valid/ready stream until
//   NUM_WORDS words have been delivered.
// - Counterpart of the absorb path: the absorb path writes the state, this block reads it out.
// PARAMETERS
// - STATE_WIDTH  1600  Keccak state width in bits (KECCAK_PACKAGE::STATE_WIDTH).
// - RATE         1344  Rate in bits (KECCAK_PACKAGE::RATE). Must be a multiple of OUT_WIDTH.
// - OUT_WIDTH    32    Output word width. Must divide LANE_WIDTH (64).
// - LEN_WIDTH    16    Width of the requested word count.
// PORTS
// - clk         in   1            System clock, rising edge.
// - resetn      in   1            Asynchronous reset, active low.
// - start       in   1            Begin a squeeze job. Sampled in IDLE only.
// - num_words   in   LEN_WIDTH    Words to output. Latched when start is accepted.
// - perm_req    out  1            Permutation request to the core. Level; held until perm_done.
// - perm_done   in   1            Core done. state_in is valid in this cycle.
// - state_in    in   STATE_WIDTH  Permuted state, lane-major order (lane 0 in bits [63:0]).
// - dout        out  OUT_WIDTH    Output word.
// - dout_valid  out  1            Output word valid.
// - dout_ready  in   1            Consumer ready. Transfer occurs when valid && ready.
// - busy        out  1            High in every state except IDLE.
// - done        out  1            One-cycle pulse when the job completes.
// BEHAVIOUR
// - Reset: all outputs are 0, FSM is in IDLE, the buffer and all counters are cleared.
//   Reset asserted mid-job aborts the job immediately; no done pulse is generated.
// - FSM states are IDLE, REQ, SQUEEZE and FIN.
//   - IDLE -> REQ: start=1 and num_words!=0. Latch rem=num_words.
//   - IDLE -> FIN: start=1 and num_words==0. perm_req never asserts.
//   - REQ: perm_req=1. On perm_done, buf <= state_in[RATE-1:0], widx <= 0, go to SQUEEZE.
//   - SQUEEZE: dout=buf[OUT_WIDTH-1:0] and dout_valid=1. On each transfer, buf shifts
//     right by OUT_WIDTH, widx++ and rem--.
//     - If this transfer makes rem==0, go to FIN.
//     - Else if widx == WORDS_PER_BLOCK-1, go to REQ (next permutation).
//   - FIN: done=1 for one cycle, then IDLE.
// - Latency:
//   - start to perm_req: 1 cycle.
//   - perm_done to first dout_valid: 1 cycle.
//   - Last transfer to done: 1 cycle.
//   - Block exhausted to next perm_req: 1 cycle.
// - Stream rules:
//   - dout and dout_valid are registered.
//   - While dout_valid=1 and dout_ready=0, dout must stay stable.
//   - dout_valid never drops without a transfer.
// - Word order follows Keccak little-endian: word k of a block = state_in[k*OUT_WIDTH +: OUT_WIDTH].
// - Boundary and ignore rules:
//   - start is ignored while busy.
//   - perm_done is ignored outside REQ.
//   - dout_ready is ignored outside SQUEEZE.
//   - perm_done arriving in the same cycle perm_req rises is legal and accepted.
//   - num_words equal to an exact multiple of WORDS_PER_BLOCK issues no trailing permutation.
//   - num_words = 2^LEN_WIDTH-1 must complete without counter overflow.
// - Widths:
//   - rem is LEN_WIDTH bits.
//   - widx is $clog2(WORDS_PER_BLOCK) bits.
//   - buf is RATE bits; capture only the rate part, never the capacity.
// STRUCTURE
// - Add to KECCAK_PACKAGE:
//   - OUT_WIDTH, WORDS_PER_BLOCK = RATE/OUT_WIDTH, CNT_LENGTH_WORD = $clog2(WORDS_PER_BLOCK).
//   - typedef enum logic [1:0] {S_IDLE, S_REQ, S_SQUEEZE, S_FIN} squeeze_state_t.
// - Single module, no sub-module. The one FSM plus the shift buffer and counters is sufficient.
// - Elaboration-time check: RATE % OUT_WIDTH == 0 and LANE_WIDTH % OUT_WIDTH == 0.
// TESTING
// - num_words=1, perm_done with state_in[31:0]=32'hDEADBEEF
//   -> one perm_req, one word 32'hDEADBEEF, done 1 cycle later.
// - num_words=42, dout_ready held high -> exactly one perm_req.
//   - Words equal state_in[31:0] .. state_in[1343:1312] in order.
//   - done follows the 42nd word; no second request.
// - num_words=43 with two distinct states S1, S2
//   -> second perm_req 1 cycle after word 42; word 43 = S2[31:0].
// - Backpressure: dout_ready=0 for 5 cycles mid-block
//   -> dout stable and dout_valid high throughout; no word lost or duplicated.
// - num_words=0 -> done 1 cycle after start, perm_req never asserted, dout_valid never asserted.
// - resetn pulsed low after word 10 of 42 -> all outputs 0 immediately.
//   - A new start with num_words=3 afterwards behaves as a fresh job.

Source files
------------

// File: rtl/keccak_squeeze_unit_pkg.sv
// Shared constants and types for the Keccak squeeze (XOF output) path.
package keccak_squeeze_unit_pkg;

  localparam int unsigned STATE_WIDTH     = 1600;
  localparam int unsigned RATE            = 1344;
  localparam int unsigned LANE_WIDTH      = 64;
  localparam int unsigned OUT_WIDTH       = 32;
  localparam int unsigned LEN_WIDTH       = 16;
  localparam int unsigned WORDS_PER_BLOCK = RATE / OUT_WIDTH;
  localparam int unsigned CNT_LENGTH_WORD = $clog2(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SQUEEZE,
    S_FIN
  } squeeze_state_t;

endpackage

// File: rtl/keccak_squeeze_unit_if.sv
// Control, permutation-handshake and output-stream signals of the squeeze unit.
// The slave modport is the squeeze unit itself; master is whoever drives it.
interface keccak_squeeze_unit_if
  import keccak_squeeze_unit_pkg::*;
#(
  parameter int unsigned StateWidth = STATE_WIDTH,
  parameter int unsigned OutWidth   = OUT_WIDTH,
  parameter int unsigned LenWidth   = LEN_WIDTH
) ();

  logic                  start;
  logic [LenWidth-1:0]   num_words;
  logic                  perm_req;
  logic                  perm_done;
  logic [StateWidth-1:0] state_in;
  logic [OutWidth-1:0]   dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start,
    input  num_words,
    input  perm_done,
    input  state_in,
    input  dout_ready,
    output perm_req,
    output dout,
    output dout_valid,
    output busy,
    output done
  );

  modport master (
    output start,
    output num_words,
    output perm_done,
    output state_in,
    output dout_ready,
    input  perm_req,
    input  dout,
    input  dout_valid,
    input  busy,
    input  done
  );

endinterface

// File: rtl/keccak_squeeze_unit.sv
// Squeeze-side output stage: requests permutations, captures the rate part of each
// permuted state and streams it out LSB-first as OutWidth-bit words until the
// requested word count has been delivered.
module keccak_squeeze_unit
  import keccak_squeeze_unit_pkg::*;
#(
  parameter int unsigned StateWidth = STATE_WIDTH,
  parameter int unsigned Rate       = RATE,
  parameter int unsigned OutWidth   = OUT_WIDTH,
  parameter int unsigned LenWidth   = LEN_WIDTH
) (
  input logic                  clk,
  input logic                  resetn,
  keccak_squeeze_unit_if.slave bus
);

  localparam int unsigned WordsPerBlock = Rate / OutWidth;
  localparam int unsigned WidxWidth     = (WordsPerBlock > 1) ? $clog2(WordsPerBlock) : 1;

  localparam logic [WidxWidth-1:0] LastWidx = WidxWidth'(WordsPerBlock - 1);
  localparam logic [WidxWidth-1:0] WidxOne  = WidxWidth'(1);
  localparam logic [LenWidth-1:0]  RemOne   = LenWidth'(1);

  if ((Rate % OutWidth) != 0 || (LANE_WIDTH % OutWidth) != 0) begin : gen_bad_width
    $error("keccak_squeeze_unit: OutWidth must divide both Rate and the lane width");
  end

  squeeze_state_t       state_q, state_d;
  logic [Rate-1:0]      rate_buf_q, rate_buf_d;
  logic [WidxWidth-1:0] widx_q, widx_d;
  logic [LenWidth-1:0]  rem_q, rem_d;
  logic                 xfer;

  // The capacity lanes are deliberately never captured.
  logic unused_capacity;
  assign unused_capacity = ^bus.state_in[StateWidth-1:Rate];

  assign xfer = (state_q == S_SQUEEZE) && bus.dout_ready;

  // Next-state, buffer shift and word/remaining counters.
  always_comb begin
    state_d    = state_q;
    rate_buf_d = rate_buf_q;
    widx_d     = widx_q;
    rem_d      = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rem_d   = bus.num_words;
          state_d = (bus.num_words == '0) ? S_FIN : S_REQ;
        end
      end
      S_REQ: begin
        if (bus.perm_done) begin
          rate_buf_d = bus.state_in[Rate-1:0];
          widx_d     = '0;
          state_d    = S_SQUEEZE;
        end
      end
      S_SQUEEZE: begin
        if (xfer) begin
          rate_buf_d = rate_buf_q >> OutWidth;
          widx_d     = widx_q + WidxOne;
          rem_d      = rem_q - RemOne;
          // Job end wins over block end, so an exact multiple never re-requests.
          if (rem_q == RemOne) begin
            state_d = S_FIN;
          end else if (widx_q == LastWidx) begin
            state_d = S_REQ;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, buffer and counter registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      rate_buf_q <= '0;
      widx_q     <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      rate_buf_q <= rate_buf_d;
      widx_q     <= widx_d;
      rem_q      <= rem_d;
    end
  end

  // All outputs are decoded straight from registers, so they are glitch-free and
  // the word on dout cannot change until the buffer shifts on a transfer.
  assign bus.perm_req   = (state_q == S_REQ);
  assign bus.dout_valid = (state_q == S_SQUEEZE);
  assign bus.dout       = rate_buf_q[OutWidth-1:0];
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_FIN);

endmodule

// File: tb/tb_keccak_squeeze_unit.sv
// Directed, table-driven bench for keccak_squeeze_unit.
module tb_keccak_squeeze_unit;
  import keccak_squeeze_unit_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  keccak_squeeze_unit_if bus ();

  keccak_squeeze_unit dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit deadbeef_mode;

  typedef struct {
    int n;           // num_words
    int stall_at;    // word index at which the consumer stalls (-1: never)
    int stall_len;   // stall length in valid cycles
    int done_delay;  // cycles of perm_req before perm_done is given (0: same cycle)
    bit noisy;       // keep start/perm_done toggling where they must be ignored
    int abort_at;    // pulse reset after this many words (-1: never)
    int exp_reqs;    // expected number of permutation requests
    bit dbeef;       // first word of block 0 is 32'hDEADBEEF
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] make_word(input int b, input int i);
    if (deadbeef_mode && b == 0 && i == 0) return 32'hDEADBEEF;
    return {8'(b + 1), 8'hC3, 8'(i), 8'(~i)};
  endfunction

  function automatic logic [STATE_WIDTH-1:0] make_state(input int b);
    logic [STATE_WIDTH-1:0] s;
    s = '1;
    for (int i = 0; i < int'(WORDS_PER_BLOCK); i++) begin
      s[i*OUT_WIDTH +: OUT_WIDTH] = make_word(b, i);
    end
    return s;
  endfunction

  task automatic run_job(input vec_t v);
    int words = 0;
    int reqs = 0;
    int blk = 0;
    int cyc = 0;
    int req_wait = 0;
    int stalled = 0;
    int last_xfer = -100;
    int budget = 2 * v.n + 200;
    bit prev_req = 1'b0;
    bit prev_valid = 1'b0;
    bit prev_ready = 1'b1;
    bit gave_done = 1'b0;
    bit seen_done = 1'b0;
    bit fin = 1'b0;
    bit rdy;
    logic [31:0] prev_dout = '0;

    deadbeef_mode = v.dbeef;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_words = 16'(v.n);
    @(negedge clk);
    bus.start     = v.noisy;
    bus.num_words = 16'd7;
    check_bit("start->perm_req", bus.perm_req, v.n != 0);
    check_bit("start->busy", bus.busy, 1'b1);

    while (!fin && cyc < budget) begin
      if (v.abort_at >= 0 && words == v.abort_at) begin
        bus.start      = 1'b0;
        bus.perm_done  = 1'b0;
        bus.dout_ready = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check_bit("abort perm_req", bus.perm_req, 1'b0);
        check_bit("abort dout_valid", bus.dout_valid, 1'b0);
        check("abort dout", 64'(bus.dout), 64'd0);
        check_bit("abort busy", bus.busy, 1'b0);
        check_bit("abort done", bus.done, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check_bit("no done after abort", bus.done, 1'b0);
          check_bit("idle after abort", bus.busy, 1'b0);
        end
        return;
      end

      if (bus.done) begin
        seen_done      = 1'b1;
        fin            = 1'b1;
        bus.start      = 1'b0;
        bus.perm_done  = 1'b0;
        bus.dout_ready = 1'b0;
        check("done latency", 64'(cyc), 64'((v.n != 0) ? last_xfer + 1 : 0));
        check_bit("done: no dout_valid", bus.dout_valid, 1'b0);
        check_bit("done: no perm_req", bus.perm_req, 1'b0);
      end else begin
        if (gave_done) check_bit("perm_done->dout_valid", bus.dout_valid, 1'b1);
        gave_done = 1'b0;
        if (prev_valid && !prev_ready) begin
          check_bit("valid held under stall", bus.dout_valid, 1'b1);
          check("dout stable under stall", 64'(bus.dout), 64'(prev_dout));
        end

        // Core model.
        if (bus.perm_req) begin
          if (!prev_req) begin
            reqs++;
            if (reqs > 1) check("block end->perm_req", 64'(cyc), 64'(last_xfer + 1));
            req_wait = 0;
          end
          if (req_wait >= v.done_delay) begin
            bus.perm_done = 1'b1;
            bus.state_in  = make_state(blk);
            blk++;
            gave_done = 1'b1;
          end else begin
            bus.perm_done = 1'b0;
            bus.state_in  = '0;
          end
          req_wait++;
        end else begin
          bus.perm_done = v.noisy;
          bus.state_in  = v.noisy ? '1 : '0;
        end

        // Consumer model.
        if (v.stall_at >= 0 && words == v.stall_at && stalled < v.stall_len) begin
          rdy = 1'b0;
          if (bus.dout_valid) stalled++;
        end else begin
          rdy = 1'b1;
        end
        bus.dout_ready = rdy;
        if (bus.dout_valid && rdy) begin
          if (words >= v.n) begin
            check("extra word", 64'(words + 1), 64'(v.n));
          end else begin
            check($sformatf("word %0d", words), 64'(bus.dout),
                  64'(make_word(words / int'(WORDS_PER_BLOCK), words % int'(WORDS_PER_BLOCK))));
          end
          words++;
          last_xfer = cyc;
        end
      end

      prev_req   = bus.perm_req;
      prev_valid = bus.dout_valid;
      prev_dout  = bus.dout;
      prev_ready = rdy;
      @(negedge clk);
      cyc++;
    end

    bus.start      = 1'b0;
    bus.perm_done  = 1'b0;
    bus.dout_ready = 1'b0;
    check_bit($sformatf("done seen (n=%0d)", v.n), seen_done, 1'b1);
    check($sformatf("word count (n=%0d)", v.n), 64'(words), 64'(v.n));
    check($sformatf("perm requests (n=%0d)", v.n), 64'(reqs), 64'(v.exp_reqs));
    check_bit("done is one cycle", bus.done, 1'b0);
    check_bit("idle after done", bus.busy, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // n, stall_at, stall_len, done_delay, noisy, abort_at, exp_reqs, dbeef
    vecs[0] = '{1, -1, 0, 0, 1'b0, -1, 1, 1'b1};
    vecs[1] = '{42, -1, 0, 0, 1'b0, -1, 1, 1'b0};
    vecs[2] = '{43, -1, 0, 0, 1'b0, -1, 2, 1'b0};
    vecs[3] = '{84, 20, 5, 2, 1'b0, -1, 2, 1'b0};
    vecs[4] = '{0, -1, 0, 0, 1'b0, -1, 0, 1'b0};
    vecs[5] = '{85, 41, 5, 1, 1'b1, -1, 3, 1'b0};
    vecs[6] = '{42, -1, 0, 0, 1'b0, 10, 1, 1'b0};
    vecs[7] = '{3, -1, 0, 0, 1'b0, -1, 1, 1'b0};
    vecs[8] = '{1000, 500, 2, 1, 1'b1, -1, 24, 1'b0};

    resetn         = 1'b0;
    bus.start      = 1'b0;
    bus.num_words  = '0;
    bus.perm_done  = 1'b0;
    bus.state_in   = '0;
    bus.dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("reset perm_req", bus.perm_req, 1'b0);
    check_bit("reset dout_valid", bus.dout_valid, 1'b0);
    check("reset dout", 64'(bus.dout), 64'd0);
    check_bit("reset busy", bus.busy, 1'b0);
    check_bit("reset done", bus.done, 1'b0);
    resetn = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      run_job(vecs[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
